// File: rtl/count_checker.sv
// count_checker: sequence monitor for binary up/down, ring and johnson counters.
// It locks onto the running sequence and checks each qualified sample against
// the legal successor of the previous one. It reports error and wrap events as
// registered pulses, keeps a saturating error count and holds the last bad value.
module count_checker #(
  parameter int WIDTH = 3,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] q_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] last_bad,
  output logic             wrap_pulse
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  localparam logic [1:0] MODE_UP      = 2'b00;
  localparam logic [1:0] MODE_DOWN    = 2'b01;
  localparam logic [1:0] MODE_RING    = 2'b10;
  localparam logic [1:0] MODE_JOHNSON = 2'b11;

  localparam logic [WIDTH-1:0] W_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  // True when no more than one bit of v is set.
  function automatic logic at_most_one(input logic [WIDTH-1:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
    return !multi;
  endfunction

  // Bit i flags a change between v[i] and v[i+1]; the top bit is always 0.
  function automatic logic [WIDTH-1:0] transitions(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] t;
    t = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      t[i] = v[i] ^ v[i+1];
    end
    return t;
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_prev;
  logic [1:0]       r_mode_q;
  logic             r_err_pulse;
  logic             r_wrap_pulse;
  logic [ERR_W-1:0] r_err_cnt;
  logic [WIDTH-1:0] r_last_bad;

  logic [WIDTH-1:0] w_succ;
  logic [WIDTH-1:0] w_start;
  logic             w_legal;
  logic             w_mode_chg;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_prev_nxt;
  logic             w_err;
  logic             w_wrap;

  assign w_mode_chg = (mode != r_mode_q);

  // Successor of the previous sample, legality of the new sample and start state for the mode.
  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_succ  = r_prev + W_ONE;
    w_legal = 1'b1;
    w_start = '0;
    unique case (mode)
      MODE_UP: begin
        w_succ = r_prev + W_ONE;
      end
      MODE_DOWN: begin
        w_succ = r_prev - W_ONE;
      end
      MODE_RING: begin
        w_succ  = {r_prev[WIDTH-2:0], r_prev[WIDTH-1]};
        w_legal = (|q_in) && at_most_one(q_in);
        w_start = W_ONE;
      end
      MODE_JOHNSON: begin
        w_succ  = {r_prev[WIDTH-2:0], ~r_prev[WIDTH-1]};
        w_legal = at_most_one(transitions(q_in));
      end
      default: begin
        w_succ = r_prev + W_ONE;
      end
    endcase
  end

  // Lock FSM next state: mode change unlocks silently, otherwise check qualified samples.
  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_err       = 1'b0;
    w_wrap      = 1'b0;
    if (r_state == ST_LOCKED && w_mode_chg) begin
      // The sample in this cycle belongs to the old mode and is dropped.
      w_state_nxt = ST_UNLOCKED;
    end else if (en) begin
      unique case (r_state)
        ST_UNLOCKED: begin
          if (w_legal) begin
            w_prev_nxt  = q_in;
            w_state_nxt = ST_LOCKED;
          end else begin
            w_err = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (q_in == w_succ) begin
            w_prev_nxt = q_in;
            w_wrap     = (q_in == w_start);
          end else begin
            w_err       = 1'b1;
            w_state_nxt = ST_UNLOCKED;
          end
        end
        default: begin
          w_state_nxt = ST_UNLOCKED;
        end
      endcase
    end
  end

  // State, pulse and error bookkeeping registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_UNLOCKED;
      r_prev       <= '0;
      r_mode_q     <= mode;
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_err_cnt    <= '0;
      r_last_bad   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev       <= w_prev_nxt;
      r_mode_q     <= mode;
      r_err_pulse  <= w_err;
      r_wrap_pulse <= w_wrap;
      if (w_err) begin
        r_last_bad <= q_in;
        if (r_err_cnt != {ERR_W{1'b1}}) begin
          r_err_cnt <= r_err_cnt + ERR_ONE;
        end
      end
    end
  end

  assign locked     = (r_state == ST_LOCKED);
  assign err_pulse  = r_err_pulse;
  assign wrap_pulse = r_wrap_pulse;
  assign err_cnt    = r_err_cnt;
  assign last_bad   = r_last_bad;

endmodule

// File: tb/tb_count_checker.sv
// Table-driven bench for count_checker (WIDTH=3). A second instance with
// ERR_W=2 sees the same stimulus to exercise error-count saturation.
module tb_count_checker;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [2:0] q_in;

  logic       locked, err_pulse, wrap_pulse;
  logic [7:0] err_cnt;
  logic [2:0] last_bad;

  logic       locked2, err_pulse2, wrap_pulse2;
  logic [1:0] err_cnt2;
  logic [2:0] last_bad2;

  int n_vec  = 0;
  int n_miss = 0;

  count_checker #(.WIDTH(3), .ERR_W(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .q_in(q_in),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
    .last_bad(last_bad), .wrap_pulse(wrap_pulse)
  );

  count_checker #(.WIDTH(3), .ERR_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .q_in(q_in),
    .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2),
    .last_bad(last_bad2), .wrap_pulse(wrap_pulse2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [2:0] q;
    logic       locked;
    logic       err;
    logic [7:0] cnt;
    logic [2:0] bad;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic r, input logic e,
                              input logic [1:0] m, input logic [2:0] q,
                              input logic l, input logic er, input logic [7:0] c,
                              input logic [2:0] b, input logic w);
    vec_t v;
    v.name = name; v.rst = r; v.en = e; v.mode = m; v.q = q;
    v.locked = l; v.err = er; v.cnt = c; v.bad = b; v.wrap = w;
    return v;
  endfunction

  // Drive one vector, clock it in, and compare both instances after the edge.
  task automatic check(input vec_t v);
    logic [1:0] exp_cnt2;
    exp_cnt2 = (v.cnt > 8'd3) ? 2'd3 : v.cnt[1:0];
    rst  = v.rst;
    en   = v.en;
    mode = v.mode;
    q_in = v.q;
    @(posedge clk);
    #1;
    n_vec++;
    if (locked !== v.locked || err_pulse !== v.err || err_cnt !== v.cnt ||
        last_bad !== v.bad || wrap_pulse !== v.wrap || err_cnt2 !== exp_cnt2) begin
      n_miss++;
      $display("FAIL %s: got locked=%0b err=%0b cnt=%0d bad=%0d wrap=%0b cnt2=%0d, want locked=%0b err=%0b cnt=%0d bad=%0d wrap=%0b cnt2=%0d",
               v.name, locked, err_pulse, err_cnt, last_bad, wrap_pulse, err_cnt2,
               v.locked, v.err, v.cnt, v.bad, v.wrap, exp_cnt2);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; q_in = 3'd0;

    // Binary up, full lap with one wrap at the second 0.
    vecs.push_back(mk("up_rst",  1, 0, 2'b00, 3'd0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("up_seed", 0, 1, 2'b00, 3'd0, 1, 0, 0, 0, 0));
    for (int i = 1; i < 8; i++)
      vecs.push_back(mk("up_run", 0, 1, 2'b00, 3'(i), 1, 0, 0, 0, 0));
    vecs.push_back(mk("up_wrap", 0, 1, 2'b00, 3'd0, 1, 0, 0, 0, 1));
    vecs.push_back(mk("up_after", 0, 1, 2'b00, 3'd1, 1, 0, 0, 0, 0));

    // Ring: bad successor, re-lock, wrap on 001.
    vecs.push_back(mk("ring_rst",  1, 0, 2'b10, 3'b000, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ring_seed", 0, 1, 2'b10, 3'b001, 1, 0, 0, 0, 0));
    vecs.push_back(mk("ring_010",  0, 1, 2'b10, 3'b010, 1, 0, 0, 0, 0));
    vecs.push_back(mk("ring_100",  0, 1, 2'b10, 3'b100, 1, 0, 0, 0, 0));
    vecs.push_back(mk("ring_bad",  0, 1, 2'b10, 3'b011, 0, 1, 1, 3'b011, 0));
    vecs.push_back(mk("ring_relk", 0, 1, 2'b10, 3'b100, 1, 0, 1, 3'b011, 0));
    vecs.push_back(mk("ring_wrap", 0, 1, 2'b10, 3'b001, 1, 0, 1, 3'b011, 1));

    // Johnson: illegal seed, then a full lap.
    vecs.push_back(mk("jn_rst",  1, 0, 2'b11, 3'b000, 0, 0, 0, 0, 0));
    vecs.push_back(mk("jn_bad",  0, 1, 2'b11, 3'b101, 0, 1, 1, 3'b101, 0));
    vecs.push_back(mk("jn_seed", 0, 1, 2'b11, 3'b000, 1, 0, 1, 3'b101, 0));
    vecs.push_back(mk("jn_001",  0, 1, 2'b11, 3'b001, 1, 0, 1, 3'b101, 0));
    vecs.push_back(mk("jn_011",  0, 1, 2'b11, 3'b011, 1, 0, 1, 3'b101, 0));
    vecs.push_back(mk("jn_111",  0, 1, 2'b11, 3'b111, 1, 0, 1, 3'b101, 0));
    vecs.push_back(mk("jn_110",  0, 1, 2'b11, 3'b110, 1, 0, 1, 3'b101, 0));
    vecs.push_back(mk("jn_100",  0, 1, 2'b11, 3'b100, 1, 0, 1, 3'b101, 0));
    vecs.push_back(mk("jn_wrap", 0, 1, 2'b11, 3'b000, 1, 0, 1, 3'b101, 1));

    // Binary down with en=0 holds (one held cycle shows a different value).
    vecs.push_back(mk("dn_rst",  1, 0, 2'b01, 3'd0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("dn_seed", 0, 1, 2'b01, 3'd3, 1, 0, 0, 0, 0));
    vecs.push_back(mk("dn_hold", 0, 0, 2'b01, 3'd3, 1, 0, 0, 0, 0));
    vecs.push_back(mk("dn_hold", 0, 0, 2'b01, 3'd3, 1, 0, 0, 0, 0));
    vecs.push_back(mk("dn_hold", 0, 0, 2'b01, 3'd6, 1, 0, 0, 0, 0));
    vecs.push_back(mk("dn_hold", 0, 0, 2'b01, 3'd3, 1, 0, 0, 0, 0));
    vecs.push_back(mk("dn_2",    0, 1, 2'b01, 3'd2, 1, 0, 0, 0, 0));
    vecs.push_back(mk("dn_1",    0, 1, 2'b01, 3'd1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("dn_wrap", 0, 1, 2'b01, 3'd0, 1, 0, 0, 0, 1));
    vecs.push_back(mk("dn_7",    0, 1, 2'b01, 3'd7, 1, 0, 0, 0, 0));

    // Five errors: ERR_W=2 instance saturates at 3, main one counts to 5.
    vecs.push_back(mk("sat_rst",  1, 0, 2'b00, 3'd0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("sat_seed", 0, 1, 2'b00, 3'd0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("sat_e1",   0, 1, 2'b00, 3'd2, 0, 1, 1, 3'd2, 0));
    vecs.push_back(mk("sat_seed", 0, 1, 2'b00, 3'd5, 1, 0, 1, 3'd2, 0));
    vecs.push_back(mk("sat_e2",   0, 1, 2'b00, 3'd7, 0, 1, 2, 3'd7, 0));
    vecs.push_back(mk("sat_seed", 0, 1, 2'b00, 3'd1, 1, 0, 2, 3'd7, 0));
    vecs.push_back(mk("sat_e3",   0, 1, 2'b00, 3'd1, 0, 1, 3, 3'd1, 0));
    vecs.push_back(mk("sat_seed", 0, 1, 2'b00, 3'd4, 1, 0, 3, 3'd1, 0));
    vecs.push_back(mk("sat_e4",   0, 1, 2'b00, 3'd6, 0, 1, 4, 3'd6, 0));
    vecs.push_back(mk("sat_seed", 0, 1, 2'b00, 3'd0, 1, 0, 4, 3'd6, 0));
    vecs.push_back(mk("sat_e5",   0, 1, 2'b00, 3'd0, 0, 1, 5, 3'd0, 0));
    vecs.push_back(mk("sat_idle", 0, 0, 2'b00, 3'd0, 0, 0, 5, 3'd0, 0));

    // Mode switch while locked, two errors, then reset mid-sequence.
    vecs.push_back(mk("mc_rst",   1, 0, 2'b00, 3'd0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("mc_seed",  0, 1, 2'b00, 3'd0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("mc_1",     0, 1, 2'b00, 3'd1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("mc_switch",0, 1, 2'b10, 3'd2, 0, 0, 0, 0, 0));
    vecs.push_back(mk("mc_e1",    0, 1, 2'b10, 3'b011, 0, 1, 1, 3'b011, 0));
    vecs.push_back(mk("mc_e2",    0, 1, 2'b10, 3'b110, 0, 1, 2, 3'b110, 0));
    vecs.push_back(mk("mc_seed",  0, 1, 2'b10, 3'b001, 1, 0, 2, 3'b110, 0));
    vecs.push_back(mk("mc_010",   0, 1, 2'b10, 3'b010, 1, 0, 2, 3'b110, 0));
    vecs.push_back(mk("mc_midrst",1, 1, 2'b10, 3'b100, 0, 0, 0, 0, 0));
    vecs.push_back(mk("mc_relk",  0, 1, 2'b10, 3'b100, 1, 0, 0, 0, 0));

    foreach (vecs[i]) check(vecs[i]);

    // Hand sequence: long run of illegal ring samples saturates the 8-bit count
    // and err_pulse keeps firing once saturated.
    check(mk("hs_rst", 1, 0, 2'b10, 3'd0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 260; i++) begin
      check(mk("hs_err", 0, 1, 2'b10, 3'b000, 0, 1, (i > 255) ? 8'd255 : 8'(i), 3'b000, 0));
    end
    check(mk("hs_last", 0, 1, 2'b10, 3'b101, 0, 1, 8'd255, 3'b101, 0));
    check(mk("hs_idle", 0, 0, 2'b10, 3'b101, 0, 0, 8'd255, 3'b101, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
